source_arbiter: RTL and testbench

- Round-robin arbiter sharing one memory source port among WAYS requesters, e.g. the fetch stage and the access stage.
- Serialises requests so only one load or store is outstanding at the source at any time.
- Latches each winning request, holds it on the source port until the source reports ready, then returns the read value and a one-cycle ready pulse to the winner.

---
 rtl/source_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_source_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_arbiter.sv
// source_arbiter
//    Round-robin arbiter that shares one memory source port among WAYS
//    requesters (for example the fetch stage and the access stage). Only one
//    load or store is ever outstanding at the source. The winning request is
//    latched, held on the source port until the source reports ready, and then
//    the read value plus a one-cycle ready pulse go back to the winner.
//
//    Optional feature macro: SOURCE_ARBITER_TIMEOUT_EN
//       When defined, a transaction that waits TIMEOUT cycles without readyIn
//       is aborted: the winner gets its ready pulse, a load returns
//       0xFFFFFFFF, and timeoutOut pulses. When undefined, BUSY waits forever
//       and timeoutOut is tied low.
//
//    Ports
//       clockIn, resetIn          clock, asynchronous active-high reset
//       addressOut, valueOut      source address and store data
//       loadOut, storeOut         source strobes, high only while BUSY
//       valueIn, readyIn          source load data and completion
//       addressesIn, valuesOutIn  per-way address / store data, way i at [32i+31:32i]
//       loadBitsIn, storeBitsIn   per-way request bits
//       valuesInOut               per-way registered load data
//       readyBitsOut              per-way one-cycle completion pulse
//       timeoutOut                aborted-transaction pulse
module source_arbiter #(
   parameter int WAYS    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   output logic [31:0]          addressOut,
   output logic [31:0]          valueOut,
   output logic                 loadOut,
   output logic                 storeOut,
   input  logic [31:0]          valueIn,
   input  logic                 readyIn,
   input  logic [WAYS*32-1:0]   addressesIn,
   input  logic [WAYS*32-1:0]   valuesOutIn,
   input  logic [WAYS-1:0]      loadBitsIn,
   input  logic [WAYS-1:0]      storeBitsIn,
   output logic [WAYS*32-1:0]   valuesInOut,
   output logic [WAYS-1:0]      readyBitsOut,
   output logic                 timeoutOut
);

   localparam int IndexWidth = $clog2(WAYS);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } ArbiterState;

   ArbiterState            state;
   ArbiterState            nextState;
   logic [IndexWidth-1:0]  grant;
   logic [IndexWidth-1:0]  pointer;
   logic [IndexWidth-1:0]  winner;
   logic [IndexWidth-1:0]  scanIndex;
   logic                   winnerFound;
   logic [WAYS-1:0]        requestBits;
   logic [31:0]            latchedAddress;
   logic [31:0]            latchedValue;
   logic                   latchedStore;
   logic                   timeoutHit;

   assign requestBits = loadBitsIn | storeBitsIn;

   // Round-robin pick: scan from the way after the last winner, wrapping
   // around, and keep the first requesting way found. The last offset lands
   // back on the pointer itself, so a lone requester can win twice in a row.
   always_comb begin
      winner      = pointer;
      winnerFound = 1'b0;
      scanIndex   = '0;
      for (int offset = 1; offset <= WAYS; offset++) begin
         scanIndex = IndexWidth'((int'(pointer) + offset) % WAYS);
         if (!winnerFound && requestBits[scanIndex]) begin
            winner      = scanIndex;
            winnerFound = 1'b1;
         end
      end
   end

`ifdef SOURCE_ARBITER_TIMEOUT_EN
   localparam int CounterWidth = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CounterWidth-1:0] waitCounter;

   // Abort fires on the BUSY cycle whose increment would make the counter
   // reach TIMEOUT; a simultaneous readyIn always takes precedence.
   assign timeoutHit = (state == BUSY) && !readyIn &&
                       (waitCounter == CounterWidth'(TIMEOUT - 1));

   // Wait counter and the registered timeout pulse. The counter restarts on
   // every grant so each transaction gets the full TIMEOUT budget.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         waitCounter <= '0;
         timeoutOut  <= 1'b0;
      end else begin
         timeoutOut <= timeoutHit;
         if (state == IDLE) begin
            waitCounter <= '0;
         end else if (state == BUSY && !readyIn && !timeoutHit) begin
            waitCounter <= waitCounter + 1'b1;
         end
      end
   end
`else
   assign timeoutHit = 1'b0;
   assign timeoutOut = 1'b0;
`endif

   // State register. Reset is asynchronous so the strobes, which decode
   // straight from the state, drop the moment resetIn rises.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. DONE always returns to IDLE, giving a bubble cycle in
   // which the finished requester drops its request before the next pick.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (|requestBits) nextState = BUSY;
         BUSY:    if (readyIn || timeoutHit) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Source port drive: everything is quiet outside BUSY, and store data is
   // only presented for stores so loads never leak stale data onto valueOut.
   always_comb begin
      addressOut = '0;
      valueOut   = '0;
      loadOut    = 1'b0;
      storeOut   = 1'b0;
      if (state == BUSY) begin
         addressOut = latchedAddress;
         loadOut    = !latchedStore;
         storeOut   = latchedStore;
         if (latchedStore) valueOut = latchedValue;
      end
   end

   // Grant bookkeeping, request latching and the per-way return path. When
   // both load and store bits are set the operation is treated as a store.
   // The ready pulse is registered so it appears in the DONE cycle only.
   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         grant          <= '0;
         pointer        <= IndexWidth'(WAYS - 1);
         latchedAddress <= '0;
         latchedValue   <= '0;
         latchedStore   <= 1'b0;
         valuesInOut    <= '0;
         readyBitsOut   <= '0;
      end else begin
         readyBitsOut <= '0;
         case (state)
            IDLE: begin
               if (|requestBits) begin
                  grant          <= winner;
                  pointer        <= winner;
                  latchedAddress <= addressesIn[int'(winner)*32 +: 32];
                  latchedValue   <= valuesOutIn[int'(winner)*32 +: 32];
                  latchedStore   <= storeBitsIn[winner];
               end
            end
            BUSY: begin
               if (readyIn) begin
                  if (!latchedStore) valuesInOut[int'(grant)*32 +: 32] <= valueIn;
                  readyBitsOut[grant] <= 1'b1;
               end else if (timeoutHit) begin
                  if (!latchedStore) valuesInOut[int'(grant)*32 +: 32] <= 32'hFFFF_FFFF;
                  readyBitsOut[grant] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_source_arbiter.sv
// tb_source_arbiter
//    Directed bench for source_arbiter with WAYS=2 and TIMEOUT=4. A table of
//    single transactions is applied in a loop, followed by hand-written
//    sequences for idle readyIn, round-robin alternation, asynchronous reset
//    mid-transaction and (when the macro is defined) the timeout abort.
//    All inputs are driven and all outputs sampled on the falling clock edge.
module tb_source_arbiter;

   localparam int WAYS = 2;

   logic                clockIn = 1'b0;
   logic                resetIn;
   logic [31:0]         addressOut;
   logic [31:0]         valueOut;
   logic                loadOut;
   logic                storeOut;
   logic [31:0]         valueIn;
   logic                readyIn;
   logic [WAYS*32-1:0]  addressesIn;
   logic [WAYS*32-1:0]  valuesOutIn;
   logic [WAYS-1:0]     loadBitsIn;
   logic [WAYS-1:0]     storeBitsIn;
   logic [WAYS*32-1:0]  valuesInOut;
   logic [WAYS-1:0]     readyBitsOut;
   logic                timeoutOut;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  loadBits;
      logic [1:0]  storeBits;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] data0;
      logic [31:0] data1;
      logic [31:0] sourceValue;
      int          readyDelay;
      logic        expLoad;
      logic        expStore;
      logic [31:0] expAddress;
      logic [31:0] expValueOut;
      logic [1:0]  expReadyBits;
      logic [31:0] expSlice0;
      logic [31:0] expSlice1;
   } VectorType;

   VectorType vectors [6];

   source_arbiter #(.WAYS(WAYS), .TIMEOUT(4)) dut (
      .clockIn      (clockIn),
      .resetIn      (resetIn),
      .addressOut   (addressOut),
      .valueOut     (valueOut),
      .loadOut      (loadOut),
      .storeOut     (storeOut),
      .valueIn      (valueIn),
      .readyIn      (readyIn),
      .addressesIn  (addressesIn),
      .valuesOutIn  (valuesOutIn),
      .loadBitsIn   (loadBitsIn),
      .storeBitsIn  (storeBitsIn),
      .valuesInOut  (valuesInOut),
      .readyBitsOut (readyBitsOut),
      .timeoutOut   (timeoutOut)
   );

   // Free-running clock, 10 time units per period.
   always #5 clockIn = ~clockIn;

   // Hard stop in case some sequence never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      resetIn     = 1'b1;
      loadBitsIn  = '0;
      storeBitsIn = '0;
      readyIn     = 1'b0;
      valueIn     = '0;
      @(negedge clockIn);
      @(negedge clockIn);
      resetIn = 1'b0;
   endtask

   // One complete transaction from the table. Starts and ends on a falling edge.
   task automatic applyStimulus(input VectorType v, input string tag);
      addressesIn = {v.addr1, v.addr0};
      valuesOutIn = {v.data1, v.data0};
      loadBitsIn  = v.loadBits;
      storeBitsIn = v.storeBits;
      @(negedge clockIn);
      checkOutput({tag, " loadOut"}, 32'(loadOut), 32'(v.expLoad));
      checkOutput({tag, " storeOut"}, 32'(storeOut), 32'(v.expStore));
      checkOutput({tag, " addressOut"}, addressOut, v.expAddress);
      checkOutput({tag, " valueOut"}, valueOut, v.expValueOut);
      checkOutput({tag, " earlyReady"}, 32'(readyBitsOut), 32'd0);
      for (int i = 0; i < v.readyDelay; i++) begin
         @(negedge clockIn);
         checkOutput({tag, " heldStrobe"}, 32'({loadOut, storeOut}), 32'({v.expLoad, v.expStore}));
      end
      readyIn = 1'b1;
      valueIn = v.sourceValue;
      @(negedge clockIn);
      readyIn = 1'b0;
      valueIn = '0;
      checkOutput({tag, " readyBits"}, 32'(readyBitsOut), 32'(v.expReadyBits));
      checkOutput({tag, " doneStrobes"}, 32'({loadOut, storeOut}), 32'd0);
      checkOutput({tag, " slice0"}, valuesInOut[31:0], v.expSlice0);
      checkOutput({tag, " slice1"}, valuesInOut[63:32], v.expSlice1);
      checkOutput({tag, " timeoutOut"}, 32'(timeoutOut), 32'd0);
      loadBitsIn  = '0;
      storeBitsIn = '0;
      @(negedge clockIn);
      checkOutput({tag, " pulseEnds"}, 32'(readyBitsOut), 32'd0);
   endtask

   initial begin
      int waited;
      logic [31:0] altAddress [2];

      vectors[0] = '{2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 2,
                     1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 32'hDEADBEEF, 32'h0};
      vectors[1] = '{2'b00, 2'b10, 32'h0, 32'h200, 32'h0, 32'h12345678, 32'hBAD0BAD0, 0,
                     1'b0, 1'b1, 32'h200, 32'h12345678, 2'b10, 32'hDEADBEEF, 32'h0};
      vectors[2] = '{2'b10, 2'b00, 32'h0, 32'h300, 32'h0, 32'h77777777, 32'hCAFEF00D, 1,
                     1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 32'hDEADBEEF, 32'hCAFEF00D};
      vectors[3] = '{2'b01, 2'b01, 32'h400, 32'h0, 32'h55AA55AA, 32'h0, 32'h11111111, 0,
                     1'b0, 1'b1, 32'h400, 32'h55AA55AA, 2'b01, 32'hDEADBEEF, 32'hCAFEF00D};
      vectors[4] = '{2'b01, 2'b00, 32'h500, 32'h600, 32'h99, 32'h0, 32'h0BADCAFE, 3,
                     1'b1, 1'b0, 32'h500, 32'h0, 2'b01, 32'h0BADCAFE, 32'hCAFEF00D};
      vectors[5] = '{2'b11, 2'b00, 32'h700, 32'h800, 32'h0, 32'h0, 32'h13579BDF, 0,
                     1'b1, 1'b0, 32'h800, 32'h0, 2'b10, 32'h0BADCAFE, 32'h13579BDF};

      resetIn     = 1'b1;
      readyIn     = 1'b0;
      valueIn     = '0;
      addressesIn = '0;
      valuesOutIn = '0;
      loadBitsIn  = '0;
      storeBitsIn = '0;
      #1;
      checkOutput("reset addressOut", addressOut, 32'h0);
      checkOutput("reset valueOut", valueOut, 32'h0);
      checkOutput("reset strobes", 32'({loadOut, storeOut}), 32'd0);
      checkOutput("reset values0", valuesInOut[31:0], 32'h0);
      checkOutput("reset values1", valuesInOut[63:32], 32'h0);
      checkOutput("reset readyBits", 32'(readyBitsOut), 32'd0);
      checkOutput("reset timeoutOut", 32'(timeoutOut), 32'd0);
      applyReset();

      // readyIn while idle with nothing requested must not disturb anything.
      readyIn = 1'b1;
      valueIn = 32'hFFFF0000;
      @(negedge clockIn);
      readyIn = 1'b0;
      valueIn = '0;
      checkOutput("idleReady readyBits", 32'(readyBitsOut), 32'd0);
      checkOutput("idleReady strobes", 32'({loadOut, storeOut}), 32'd0);
      checkOutput("idleReady values0", valuesInOut[31:0], 32'h0);
      checkOutput("idleReady addressOut", addressOut, 32'h0);
      @(negedge clockIn);
      checkOutput("idleReady later", 32'(readyBitsOut), 32'd0);

      for (int n = 0; n < 6; n++) begin
         applyStimulus(vectors[n], $sformatf("vec%0d", n));
      end

      // Both ways requesting continuously from reset: grants alternate 0,1,0,1
      // with a strobe-free bubble between transactions.
      applyReset();
      altAddress[0] = 32'h1000;
      altAddress[1] = 32'h2000;
      addressesIn   = {altAddress[1], altAddress[0]};
      loadBitsIn    = 2'b11;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         while (!loadOut && waited < 20) begin
            @(negedge clockIn);
            waited++;
         end
         checkOutput($sformatf("alt%0d strobe", k), 32'(loadOut), 32'd1);
         checkOutput($sformatf("alt%0d address", k), addressOut, altAddress[k % 2]);
         readyIn = 1'b1;
         valueIn = 32'hA0 + 32'(k);
         @(negedge clockIn);
         readyIn = 1'b0;
         checkOutput($sformatf("alt%0d readyBits", k), 32'(readyBitsOut), 32'(1 << (k % 2)));
         checkOutput($sformatf("alt%0d doneStrobe", k), 32'(loadOut), 32'd0);
         @(negedge clockIn);
         checkOutput($sformatf("alt%0d bubble", k), 32'({loadOut, readyBitsOut}), 32'd0);
      end
      loadBitsIn = '0;
      checkOutput("alt slice0", valuesInOut[31:0], 32'hA2);
      checkOutput("alt slice1", valuesInOut[63:32], 32'hA3);
      @(negedge clockIn);

      // Asynchronous reset in the middle of a BUSY cycle, source never ready.
      addressesIn = {32'h3000, 32'h0};
      loadBitsIn  = 2'b10;
      @(negedge clockIn);
      checkOutput("midReset busy", 32'(loadOut), 32'd1);
      #2;
      resetIn = 1'b1;
      #1;
      checkOutput("midReset strobes", 32'({loadOut, storeOut}), 32'd0);
      checkOutput("midReset address", addressOut, 32'h0);
      checkOutput("midReset readyBits", 32'(readyBitsOut), 32'd0);
      @(negedge clockIn);
      loadBitsIn = '0;
      resetIn    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clockIn);
         checkOutput("midReset noPulse", 32'(readyBitsOut), 32'd0);
      end
      addressesIn = {32'h5000, 32'h4000};
      loadBitsIn  = 2'b11;
      @(negedge clockIn);
      checkOutput("postReset strobe", 32'(loadOut), 32'd1);
      checkOutput("postReset way0", addressOut, 32'h4000);
      readyIn = 1'b1;
      valueIn = 32'h4444;
      @(negedge clockIn);
      readyIn    = 1'b0;
      loadBitsIn = '0;
      checkOutput("postReset readyBits", 32'(readyBitsOut), 32'd1);
      @(negedge clockIn);

`ifdef SOURCE_ARBITER_TIMEOUT_EN
      // Source never answers: four BUSY cycles, then abort with a pulse.
      addressesIn = {32'h0, 32'h6000};
      loadBitsIn  = 2'b01;
      @(negedge clockIn);
      checkOutput("timeout busy1", 32'(loadOut), 32'd1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clockIn);
         checkOutput($sformatf("timeout busy%0d", i), 32'({loadOut, timeoutOut}), 32'b10);
      end
      @(negedge clockIn);
      loadBitsIn = '0;
      checkOutput("timeout pulse", 32'(timeoutOut), 32'd1);
      checkOutput("timeout readyBits", 32'(readyBitsOut), 32'd1);
      checkOutput("timeout slice0", valuesInOut[31:0], 32'hFFFFFFFF);
      checkOutput("timeout strobe", 32'(loadOut), 32'd0);
      @(negedge clockIn);
      checkOutput("timeout pulseEnds", 32'(timeoutOut), 32'd0);
`else
      checkOutput("timeout tiedLow", 32'(timeoutOut), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
